// File: rtl/device_arbiter_rr.sv
// N-controller to single-device arbiter for one memory bank: round-robin or fixed
// priority grant, zero-latency acceptance and an in-order read-ack FIFO.
module device_arbiter_rr #(
    parameter int         NUM_CONTROLLERS = 4,
    parameter int         ADDRESS_WIDTH   = 26,
    parameter int         DATA_WIDTH      = 32,
    parameter logic [3:0] DEVICE_BANK     = 4'd0,
    parameter int         ACK_FIFO_DEPTH  = 8,
    parameter bit         ROUND_ROBIN     = 1'b1
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic [NUM_CONTROLLERS-1:0]               i_request,
    input  logic [NUM_CONTROLLERS-1:0]               i_write,
    output logic [NUM_CONTROLLERS-1:0]               o_busy,
    output logic [NUM_CONTROLLERS-1:0]               o_ack,
    input  logic [NUM_CONTROLLERS*4-1:0]             i_bank,
    input  logic [NUM_CONTROLLERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [NUM_CONTROLLERS*DATA_WIDTH-1:0]    i_data,
    output logic [NUM_CONTROLLERS*DATA_WIDTH-1:0]    o_data,
    output logic                                     o_device_request,
    output logic                                     o_device_write,
    input  logic                                     i_device_busy,
    input  logic                                     i_device_ack,
    output logic [ADDRESS_WIDTH-1:0]                 o_device_address,
    input  logic [DATA_WIDTH-1:0]                    i_device_data,
    output logic [DATA_WIDTH-1:0]                    o_device_data,
    output logic [$clog2(ACK_FIFO_DEPTH+1)-1:0]      o_pending,
    output logic                                     o_ack_error
);

    localparam int N     = NUM_CONTROLLERS;
    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int IDX_W = $clog2(NUM_CONTROLLERS);
    localparam int PTR_W = $clog2(ACK_FIFO_DEPTH);
    localparam int CNT_W = $clog2(ACK_FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(ACK_FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CONTROLLERS - 1);

    logic [N-1:0]     eligible_s;
    logic [N-1:0]     grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] scan_start_s;
    logic [IDX_W-1:0] scan_idx_s;
    logic             scan_found_s;
    logic             grant_write_s;
    logic [AW-1:0]    grant_address_s;
    logic [DW-1:0]    grant_data_s;
    logic             full_s;
    logic             blocked_s;
    logic             device_request_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             unexpected_ack_s;

    logic [IDX_W-1:0] next_q, next_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             ack_error_q, ack_error_d;
    logic [N-1:0]     fifo_q [ACK_FIFO_DEPTH];

    // Controllers aimed at another bank are invisible to this arbiter.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < N; i++) begin
            eligible_s[i] = i_request[i] && (i_bank[i*4 +: 4] == DEVICE_BANK);
        end
    end

    // Grant scan: first eligible index from the start point, wrapping modulo N.
    always_comb begin
        grant_s      = '0;
        grant_idx_s  = '0;
        scan_found_s = 1'b0;
        scan_idx_s   = '0;
        if (ROUND_ROBIN) begin
            scan_start_s = next_q;
        end else begin
            scan_start_s = '0;
        end
        for (int k = 0; k < N; k++) begin
            scan_idx_s = IDX_W'((int'(scan_start_s) + k) % N);
            if (!scan_found_s && eligible_s[scan_idx_s]) begin
                grant_s[scan_idx_s] = 1'b1;
                grant_idx_s         = scan_idx_s;
                scan_found_s        = 1'b1;
            end else begin
                scan_found_s = scan_found_s;
            end
        end
    end

    // AND-OR mux of the granted controller's fields; all zero without a grant.
    always_comb begin
        grant_write_s   = 1'b0;
        grant_address_s = '0;
        grant_data_s    = '0;
        for (int i = 0; i < N; i++) begin
            grant_write_s   = grant_write_s | (grant_s[i] & i_write[i]);
            grant_address_s = grant_address_s | ({AW{grant_s[i]}} & i_address[i*AW +: AW]);
            grant_data_s    = grant_data_s | ({DW{grant_s[i]}} & i_data[i*DW +: DW]);
        end
    end

    // Handshake: a read is held off while the ack FIFO is full, even if it pops this cycle.
    always_comb begin
        full_s           = (pending_q == FULL_COUNT);
        blocked_s        = scan_found_s && !grant_write_s && full_s;
        device_request_s = (|eligible_s) && !blocked_s && !i_reset;
        accept_s         = device_request_s && !i_device_busy;
        push_s           = accept_s && !grant_write_s;
        pop_s            = i_device_ack && (pending_q != '0) && !i_reset;
        unexpected_ack_s = i_device_ack && (pending_q == '0);
    end

    // Next-state: round-robin pointer, FIFO pointers, occupancy and sticky error.
    always_comb begin
        next_d      = next_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pending_d   = pending_q;
        ack_error_d = ack_error_q | unexpected_ack_s;

        if (accept_s && ROUND_ROBIN) begin
            if (grant_idx_s == LAST_IDX) begin
                next_d = '0;
            end else begin
                next_d = grant_idx_s + IDX_W'(1);
            end
        end else begin
            next_d = next_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    // State registers with synchronous reset; outstanding reads are discarded.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            next_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            ack_error_q <= 1'b0;
        end else begin
            next_q      <= next_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pending_q   <= pending_d;
            ack_error_q <= ack_error_d;
        end
    end

    // Ack FIFO storage holds the one-hot owner of each outstanding read.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= grant_s;
        end
    end

    assign o_busy           = eligible_s & ~(grant_s & {N{accept_s}});
    assign o_ack            = pop_s ? fifo_q[rd_ptr_q] : '0;
    assign o_data           = {N{i_device_data}};
    assign o_device_request = device_request_s;
    assign o_device_write   = grant_write_s;
    assign o_device_address = grant_address_s;
    assign o_device_data    = grant_data_s;
    assign o_pending        = pending_q;
    assign o_ack_error      = ack_error_q;

endmodule

// File: tb/tb_device_arbiter_rr.sv
// Directed bench for device_arbiter_rr: a round-robin and a fixed-priority instance
// share stimulus; expected values are hand-derived per step.
module tb_device_arbiter_rr;

    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, wr;
    logic [N*4-1:0] bank;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic          dbusy, dack;
    logic [DW-1:0] drdata;

    logic [N-1:0]    rr_busy, rr_ack, fp_busy, fp_ack;
    logic [N*DW-1:0] rr_data, fp_data;
    logic            rr_dreq, rr_dwr, fp_dreq, fp_dwr;
    logic [AW-1:0]   rr_daddr, fp_daddr;
    logic [DW-1:0]   rr_ddata, fp_ddata;
    logic [CW-1:0]   rr_pend, fp_pend;
    logic            rr_err, fp_err;

    int checks = 0;
    int errors = 0;
    int g_seq [4] = '{1, 3, 0, 1};

    always #5 clk = ~clk;

    device_arbiter_rr #(.NUM_CONTROLLERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .DEVICE_BANK(4'd0), .ACK_FIFO_DEPTH(DEPTH), .ROUND_ROBIN(1'b1)) u_rr (
        .i_clk(clk), .i_reset(rst), .i_request(req), .i_write(wr), .o_busy(rr_busy),
        .o_ack(rr_ack), .i_bank(bank), .i_address(addr), .i_data(wdata), .o_data(rr_data),
        .o_device_request(rr_dreq), .o_device_write(rr_dwr), .i_device_busy(dbusy),
        .i_device_ack(dack), .o_device_address(rr_daddr), .i_device_data(drdata),
        .o_device_data(rr_ddata), .o_pending(rr_pend), .o_ack_error(rr_err));

    device_arbiter_rr #(.NUM_CONTROLLERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .DEVICE_BANK(4'd0), .ACK_FIFO_DEPTH(DEPTH), .ROUND_ROBIN(1'b0)) u_fp (
        .i_clk(clk), .i_reset(rst), .i_request(req), .i_write(wr), .o_busy(fp_busy),
        .o_ack(fp_ack), .i_bank(bank), .i_address(addr), .i_data(wdata), .o_data(fp_data),
        .o_device_request(fp_dreq), .o_device_write(fp_dwr), .i_device_busy(dbusy),
        .i_device_ack(dack), .o_device_address(fp_daddr), .i_device_data(drdata),
        .o_device_data(fp_ddata), .o_pending(fp_pend), .o_ack_error(fp_err));

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << (i % 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        addr   = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
        wdata  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        rst    = 1'b1;
        req    = 4'b0001;
        wr     = 4'b0000;
        bank   = 16'h0000;
        dbusy  = 1'b0;
        dack   = 1'b0;
        drdata = 16'h0000;

        // reset behaviour
        #1;
        check("rst_dreq", 64'(rr_dreq), 64'd0);
        check("rst_busy", 64'(rr_busy), 64'h1);
        check("rst_ack", 64'(rr_ack), 64'h0);
        tick(); req = 4'b0000; tick(); rst = 1'b0; #1;
        check("rst_pend", 64'(rr_pend), 64'd0);
        check("rst_err", 64'(rr_err), 64'd0);
        check("idle_dreq", 64'(rr_dreq), 64'd0);
        check("idle_busy", 64'(rr_busy), 64'h0);
        tick();

        // round-robin fairness with acks one cycle later
        for (int k = 0; k < 8; k++) begin
            req = 4'b1111; wr = 4'b0000; dack = (k > 0); drdata = 16'h5500 + 16'(k);
            #1;
            check("rr_busy", 64'(rr_busy), 64'(4'b1111 & ~oh(k)));
            check("rr_addr", 64'(rr_daddr), 64'(16'h0A00 + 16'(k % 4)));
            check("rr_ack", 64'(rr_ack), (k > 0) ? 64'(oh(k + 3)) : 64'h0);
            check("rr_data", 64'(rr_data), 64'({4{drdata}}));
            check("rr_pend", 64'(rr_pend), (k > 0) ? 64'd1 : 64'd0);
            tick();
        end
        req = 4'b0000; dack = 1'b1; drdata = 16'h55AA; #1;
        check("rr_last_ack", 64'(rr_ack), 64'h8);
        tick(); dack = 1'b0; #1;
        check("rr_drained", 64'(rr_pend), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;

        // fixed priority: 1 wins over 3 until it drops
        req = 4'b1010; wr = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fp_busy", 64'(fp_busy), 64'h8);
            check("fp_addr", 64'(fp_daddr), 64'h0A01);
            check("fp_data", 64'(fp_ddata), 64'hD001);
            check("fp_wr", 64'(fp_dwr), 64'd1);
            tick();
        end
        req = 4'b1000; wr = 4'b1000; #1;
        check("fp_busy3", 64'(fp_busy), 64'h0);
        check("fp_addr3", 64'(fp_daddr), 64'h0A03);
        check("fp_data3", 64'(fp_ddata), 64'hD003);
        tick(); req = 4'b0000; wr = 4'b0000; #1;
        check("fp_pend", 64'(fp_pend), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;

        // FIFO full: four reads fill it, fifth blocked, write still passes
        req = 4'b0001; wr = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fill_busy", 64'(rr_busy), 64'h0);
            check("fill_pend", 64'(rr_pend), 64'(k));
            tick();
        end
        #1;
        check("full_pend", 64'(rr_pend), 64'd4);
        check("full_busy", 64'(rr_busy), 64'h1);
        check("full_dreq", 64'(rr_dreq), 64'd0);
        tick();
        req = 4'b0011; wr = 4'b0010; #1;
        check("full_wr_busy", 64'(rr_busy), 64'h1);
        check("full_wr_dreq", 64'(rr_dreq), 64'd1);
        check("full_wr_addr", 64'(rr_daddr), 64'h0A01);
        tick();
        req = 4'b0001; wr = 4'b0000; dack = 1'b1; drdata = 16'h7777; #1;
        check("full_pop_ack", 64'(rr_ack), 64'h1);
        check("full_pop_busy", 64'(rr_busy), 64'h1);
        check("full_pop_dreq", 64'(rr_dreq), 64'd0);
        tick(); dack = 1'b0; #1;
        check("after_pop_pend", 64'(rr_pend), 64'd3);
        check("after_pop_busy", 64'(rr_busy), 64'h0);
        tick(); req = 4'b0000; #1;
        check("refill_pend", 64'(rr_pend), 64'd4);
        for (int k = 0; k < 4; k++) begin
            dack = 1'b1; #1;
            check("drain_ack", 64'(rr_ack), 64'h1);
            check("drain_pend", 64'(rr_pend), 64'(4 - k));
            tick();
        end
        dack = 1'b0; #1;
        check("drain_done", 64'(rr_pend), 64'd0);

        // 12 reads across pointer wrap, simultaneous push/pop at two pending
        for (int k = 0; k < 12; k++) begin
            req = 4'b1111; wr = 4'b0000; dack = (k >= 2); #1;
            check("wrap_busy", 64'(rr_busy), 64'(4'b1111 & ~oh(k + 1)));
            check("wrap_ack", 64'(rr_ack), (k >= 2) ? 64'(oh(k + 3)) : 64'h0);
            check("wrap_pend", 64'(rr_pend), (k < 2) ? 64'(k) : 64'd2);
            tick();
        end
        req = 4'b0000;
        for (int k = 12; k < 14; k++) begin
            dack = 1'b1; #1;
            check("wrap_tail_ack", 64'(rr_ack), 64'(oh(k + 3)));
            tick();
        end
        dack = 1'b0; #1;
        check("wrap_done", 64'(rr_pend), 64'd0);

        // bank filter: controller 2 targets bank 3
        bank = 16'h0300; req = 4'b0100; #1;
        check("bank_busy", 64'(rr_busy), 64'h0);
        check("bank_dreq", 64'(rr_dreq), 64'd0);
        tick();
        req = 4'b1111; wr = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bank_rr_busy", 64'(rr_busy), 64'(4'b1011 & ~oh(g_seq[k])));
            check("bank_rr_addr", 64'(rr_daddr), 64'(16'h0A00 + 16'(g_seq[k])));
            tick();
        end

        // device busy: nothing accepted, pointer held
        dbusy = 1'b1; req = 4'b1011; wr = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("dbusy_busy", 64'(rr_busy), 64'hB);
            check("dbusy_dreq", 64'(rr_dreq), 64'd1);
            check("dbusy_addr", 64'(rr_daddr), 64'h0A03);
            check("dbusy_pend", 64'(rr_pend), 64'd0);
            tick();
        end
        dbusy = 1'b0; #1;
        check("dbusy_release", 64'(rr_busy), 64'h3);
        tick(); req = 4'b0000; dack = 1'b1; #1;
        check("dbusy_ack", 64'(rr_ack), 64'h8);
        tick(); dack = 1'b0; bank = 16'h0000; #1;
        check("dbusy_pend_end", 64'(rr_pend), 64'd0);
        check("err_clear", 64'(rr_err), 64'd0);

        // unexpected ack and reset with reads outstanding
        dack = 1'b1; #1;
        check("unexp_ack", 64'(rr_ack), 64'h0);
        tick(); dack = 1'b0; #1;
        check("err_set", 64'(rr_err), 64'd1);
        tick(); #1;
        check("err_held", 64'(rr_err), 64'd1);
        req = 4'b1111; wr = 4'b0000;
        tick(); tick(); tick();
        req = 4'b0000; #1;
        check("pre_rst_pend", 64'(rr_pend), 64'd3);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("post_rst_pend", 64'(rr_pend), 64'd0);
        check("post_rst_err", 64'(rr_err), 64'd0);
        dack = 1'b1; #1;
        check("post_rst_ack", 64'(rr_ack), 64'h0);
        tick(); dack = 1'b0; #1;
        check("post_rst_err_set", 64'(rr_err), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/device_arbiter_rr.md
Name: device_arbiter_rr

Overview:
- N-controller to single-device arbiter for one memory bank of the SC64 bus fabric; sits between bus masters (N64 PI, USB, SD DMA, CPU) and a device controller (SDRAM, flash, BRAM).
- Parametrised successor to the fixed-priority arbiter:
  - selectable round-robin or fixed priority;
  - generic data width;
  - sized in-order read-ack FIFO with occupancy output;
  - a read is never issued to the device while the ack FIFO is full;
  - sticky error flag for unexpected device acks.

Parameters:
- NUM_CONTROLLERS, 4, number of requesting controllers (>=2).
- ADDRESS_WIDTH, 26, device address width.
- DATA_WIDTH, 32, data word width.
- DEVICE_BANK, 4'd0, bank ID this arbiter serves.
- ACK_FIFO_DEPTH, 8, outstanding reads tracked; power of two, >=2.
- ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous active-high reset.
- i_request  input  N  per-controller request.
- i_write  input  N  per-controller write (1) / read (0).
- o_busy  output  N  request not accepted this cycle; controller holds request.
- o_ack  output  N  read-data valid, one-hot to the originating controller.
- i_bank  input  N*4  per-controller target bank.
- i_address  input  N*ADDRESS_WIDTH  per-controller address.
- i_data  input  N*DATA_WIDTH  per-controller write data.
- o_data  output  N*DATA_WIDTH  read data, i_device_data broadcast to all slices.
- o_device_request  output  1  request to device.
- o_device_write  output  1  write strobe to device.
- i_device_busy  input  1  device cannot accept this cycle.
- i_device_ack  input  1  device read data valid.
- o_device_address  output  ADDRESS_WIDTH  granted address.
- i_device_data  input  DATA_WIDTH  device read data.
- o_device_data  output  DATA_WIDTH  granted write data.
- o_pending  output  clog2(ACK_FIFO_DEPTH+1)  outstanding read count.
- o_ack_error  output  1  sticky: i_device_ack seen with no outstanding read.

Behaviour:
- eligible[i] = i_request[i] && i_bank[i] == DEVICE_BANK. Controllers targeting other banks are ignored; their o_busy is 0.
- Grant, combinational, one-hot, zero when nothing is eligible:
  - ROUND_ROBIN=1: first eligible index scanning upward from r_next, wrapping modulo N.
  - ROUND_ROBIN=0: lowest eligible index.
- full = (o_pending == ACK_FIFO_DEPTH). blocked = granted is a read && full. A pop in the same cycle does not clear blocked.
- o_device_request = |eligible && !blocked && !i_reset.
- o_device_write, o_device_address, o_device_data = granted controller's fields; all zero when there is no grant.
- accept = o_device_request && !i_device_busy.
- o_busy[i] = eligible[i] && !(grant[i] && accept). Zero-latency acceptance: a transfer completes in the cycle its o_busy is low.
- On accept, registered:
  - if read, push the one-hot grant into the FIFO;
  - if ROUND_ROBIN, r_next <= (granted index + 1) mod N. Updated on reads and writes; not updated when no accept.
- Ack path, combinational:
  - o_ack = head entry when i_device_ack && o_pending != 0, else 0;
  - on that cycle the head is popped.
- Unexpected ack: i_device_ack with o_pending == 0 produces o_ack = 0, sets o_ack_error, and leaves pointers unchanged.
- Simultaneous push and pop: both pointers advance and o_pending is unchanged. Push into a full FIFO cannot occur (blocked).
- Pointers are clog2(DEPTH) bits and wrap naturally. o_pending is maintained as a separate counter.
- Reset, synchronous:
  - r_next=0, pointers=0, o_pending=0, o_ack_error=0;
  - while i_reset is high: o_device_request=0, o_busy=eligible, o_ack=0.
  - Reset mid-operation discards outstanding reads. Acks arriving after reset are treated as unexpected and set o_ack_error.
- FIFO memory contents need no reset.

Test Plan:
- Round-robin fairness: N=4, ROUND_ROBIN=1, controllers 0..3 request continuous reads, device never busy, acks 1 cycle later -> grants 0,1,2,3,0,...; each o_ack one-hot in the same order; o_pending peaks at 1.
- Fixed priority: ROUND_ROBIN=0, controllers 1 and 3 request writes -> 1 granted until it drops its request; o_busy[3]=1 throughout, then 3 granted; o_device_address tracks the granted controller.
- FIFO full: DEPTH=4, 5 back-to-back reads with no acks -> o_pending reaches 4; 5th read sees o_busy=1 and o_device_request=0; a write from another controller is still accepted; one ack -> 5th read accepted next cycle.
- Simultaneous push/pop at o_pending=2 -> o_pending stays 2; ack order matches issue order across pointer wrap (12 reads, DEPTH=4).
- Bank filter and busy: controller 2 with i_bank != DEVICE_BANK -> o_busy[2]=0, never granted. i_device_busy=1 for 3 cycles -> every eligible o_busy=1, no FIFO push, r_next unchanged.
- Errors and reset: ack with o_pending=0 -> o_ack=0, o_ack_error=1 held. Reset with 3 reads pending -> o_pending=0, o_ack_error=0; a subsequent ack sets o_ack_error again.
